// File: rtl/opcode_issue_pipe.sv
// Decode/execute opcode issue pipe with RAW hazard stall and HALT.
// Ports:
//   clk, reset (sync, active-low)
//   instr_valid/instr/instr_ready : fetch handshake
//   q6, q10 : decode and execute opcodes
//   ex_rd/ex_rs1/ex_rs2 : execute-stage register fields
//   stall, halted, illegal : status flags
//   retired_cnt, stall_cnt : event counters
module opcode_issue_pipe #(
    parameter int OPW  = 6,
    parameter int RAW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [OPW-1:0]  q6,
    output logic [OPW-1:0]  q10,
    output logic [RAW-1:0]  ex_rd,
    output logic [RAW-1:0]  ex_rs1,
    output logic [RAW-1:0]  ex_rs2,
    output logic            stall,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] retired_cnt,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
    localparam logic [OPW-1:0] OP_STORE = OPW'(3);
    localparam logic [OPW-1:0] OP_HALT  = {OPW{1'b1}};

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [RAW-1:0] rd;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
    } stage_t;

    localparam stage_t NOP_STAGE = '0;

    stage_t dec;
    stage_t exe;
    stage_t fetched;

    logic in_legal;
    logic accept;
    logic use_rd;
    logic use_rs1;
    logic use_rs2;
    logic ex_writes;
    logic hit;

    // Split the fetched word and squash illegal opcodes to an all-zero NOP.
    always_comb begin
        fetched     = NOP_STAGE;
        fetched.op  = instr[31 -: OPW];
        fetched.rd  = instr[25 -: RAW];
        fetched.rs1 = instr[20 -: RAW];
        fetched.rs2 = instr[15 -: RAW];
        in_legal    = (fetched.op <= OP_STORE) || (fetched.op == OP_HALT);
        if (!in_legal) begin
            fetched = NOP_STAGE;
        end
    end

    // Which decode fields are actually read as source registers.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (dec.op)
            OP_ADD, OP_SUB: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_STORE: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            default: begin
                use_rd  = 1'b0;
            end
        endcase
    end

    assign ex_writes = (exe.op == OP_ADD) || (exe.op == OP_SUB);

    assign hit = (use_rd  && (dec.rd  == exe.rd))
              || (use_rs1 && (dec.rs1 == exe.rd))
              || (use_rs2 && (dec.rs2 == exe.rd));

    // r0 is hardwired zero, so a write to it never creates a dependency.
    assign stall = ex_writes && (exe.rd != '0) && hit;

    assign instr_ready = !stall && !halted && reset;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dec         <= NOP_STAGE;
            exe         <= NOP_STAGE;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (stall) begin
                // Hold decode, inject a bubble; this clears the hazard next cycle.
                exe <= NOP_STAGE;
            end else begin
                exe <= dec;
                if (accept) begin
                    dec <= fetched;
                end else begin
                    dec <= NOP_STAGE;
                end
            end

            illegal <= accept && !in_legal;

            if (accept && (fetched.op == OP_HALT)) begin
                halted <= 1'b1;
            end

            if ((exe.op == OP_ADD) || (exe.op == OP_SUB)
                || (exe.op == OP_STORE)) begin
                retired_cnt <= retired_cnt + CNTW'(1);
            end

            if (stall && (stall_cnt != {CNTW{1'b1}})) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

    assign q6     = dec.op;
    assign q10    = exe.op;
    assign ex_rd  = exe.rd;
    assign ex_rs1 = exe.rs1;
    assign ex_rs2 = exe.rs2;

endmodule
